// File: rtl/dmux8way_dispatch_if.sv
// Request channel of the 8-way demux dispatcher.
// Carries one routing request per valid/ready handshake:
//   in_valid : request present (master -> slave)
//   in_ready : slave can take the request (slave -> master)
//   in_dest  : destination 0..7, bit0 drives sel_0
//   in_data  : value to strobe onto the demux data input
interface dmux8way_dispatch_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_dest;
  logic       in_data;

  modport master (output in_valid, output in_dest, output in_data, input in_ready);
  modport slave  (input in_valid, input in_dest, input in_data, output in_ready);
endinterface

// File: rtl/dmux8way_dispatch.sv
// Upstream sequencer for an 8-way combinational demux.
// Requests are buffered in a DEPTH-entry FIFO and replayed one at a time as
// SETUP (selects move, a=0) -> PULSE (a=data for PULSE_LEN cycles)
// -> HOLD (a=0, done=1). Selects only ever move while a is low, so the
// downstream demux never glitches onto a wrong output.
// Ports:
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   req          : request channel (slave side), in_ready = !full
//   a            : demux data input (registered)
//   sel_0..sel_2 : demux selects (registered)
//   done         : one-cycle pulse in the HOLD cycle of each request
//   busy         : FSM not idle or FIFO not empty
//   level        : FIFO occupancy 0..DEPTH
module dmux8way_dispatch #(
  parameter int DEPTH     = 4,
  parameter int PULSE_LEN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  dmux8way_dispatch_if.slave       req,
  output logic                     a,
  output logic                     sel_0,
  output logic                     sel_1,
  output logic                     sel_2,
  output logic                     done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // FIFO storage: {dest[2:0], data}
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic [AW:0]   level_d;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          a_q;
  logic          done_q;
  logic          data_q;
  logic [2:0]    sel_q;

  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic [3:0]    head_s;

  // FIFO status, handshake and next occupancy.
  always_comb begin
    full_s  = (level_q == (AW+1)'(DEPTH));
    empty_s = (level_q == (AW+1)'(0));
    // Push is refused whenever full, even if a pop frees a slot this cycle.
    push_s  = req.in_valid & ~full_s;
    // The FSM only consumes a new entry from IDLE or from HOLD (back-to-back).
    pop_s   = ~empty_s & ((state_q == S_IDLE) | (state_q == S_HOLD));
    head_s  = mem_q[rd_ptr_q];
    if (push_s && !pop_s) begin
      level_d = level_q + (AW+1)'(1);
    end else if (!push_s && pop_s) begin
      level_d = level_q - (AW+1)'(1);
    end else begin
      level_d = level_q;
    end
  end

  // FIFO pointers, occupancy and storage; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      level_q  <= (AW+1)'(0);
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {req.in_dest, req.in_data};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
    end
  end

  // Strobe sequencer with registered a/sel/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= CW'(0);
      a_q     <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= 1'b0;
      sel_q   <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          a_q    <= 1'b0;
          done_q <= 1'b0;
          if (pop_s) begin
            // Selects move on entry to SETUP, while a is still low.
            sel_q   <= head_s[3:1];
            data_q  <= head_s[0];
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          a_q     <= data_q;
          cnt_q   <= CW'(PULSE_LEN - 1);
          state_q <= S_PULSE;
        end
        S_PULSE: begin
          if (cnt_q == CW'(0)) begin
            a_q     <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_HOLD: begin
          done_q <= 1'b0;
          if (pop_s) begin
            sel_q   <= head_s[3:1];
            data_q  <= head_s[0];
            state_q <= S_SETUP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          a_q     <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req.in_ready = ~full_s;
  assign busy         = (state_q != S_IDLE) | ~empty_s;
  assign level        = level_q;
  assign a            = a_q;
  assign done         = done_q;
  assign sel_0        = sel_q[0];
  assign sel_1        = sel_q[1];
  assign sel_2        = sel_q[2];

endmodule

// File: tb/tb_dmux8way_dispatch.sv
// Scoreboard bench: DUT 0 uses PULSE_LEN=1, DUT 1 uses PULSE_LEN=3.
module tb_dmux8way_dispatch;

  typedef struct {
    logic [2:0] dest;
    logic       data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmux8way_dispatch_if if0 ();
  dmux8way_dispatch_if if1 ();

  logic       a0, s0_0, s0_1, s0_2, done0, busy0;
  logic       a1, s1_0, s1_1, s1_2, done1, busy1;
  logic [2:0] level0, level1;

  dmux8way_dispatch #(.DEPTH(4), .PULSE_LEN(1)) dut0 (
    .clk(clk), .rst(rst), .req(if0.slave), .a(a0),
    .sel_0(s0_0), .sel_1(s0_1), .sel_2(s0_2),
    .done(done0), .busy(busy0), .level(level0)
  );

  dmux8way_dispatch #(.DEPTH(4), .PULSE_LEN(3)) dut1 (
    .clk(clk), .rst(rst), .req(if1.slave), .a(a1),
    .sel_0(s1_0), .sel_1(s1_1), .sel_2(s1_2),
    .done(done1), .busy(busy1), .level(level1)
  );

  exp_t q0[$];
  exp_t q1[$];
  int   last_done [2];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  task automatic drive(input int k, input logic v, input logic [2:0] d, input logic x);
    if (k == 0) begin
      if0.in_valid = v; if0.in_dest = d; if0.in_data = x;
    end else begin
      if1.in_valid = v; if1.in_dest = d; if1.in_data = x;
    end
  endtask

  // Expected done cycle: idle path (accept + 3 + PL) or right behind the previous request.
  task automatic push_exp(input int k, input logic [2:0] d, input logic x);
    exp_t e;
    int   pl;
    pl     = (k == 0) ? 1 : 3;
    e.dest = d;
    e.data = x;
    e.cyc  = imax(cyc + 3 + pl, last_done[k] + pl + 2);
    last_done[k] = e.cyc;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Called just after a rising edge; request is accepted at the next edge.
  task automatic send(input int k, input logic [2:0] d, input logic x);
    drive(k, 1'b1, d, x);
    chk("send_ready", (k == 0) ? if0.in_ready : if1.in_ready, 1);
    push_exp(k, d, x);
    @(posedge clk); #1;
    drive(k, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy0 || busy1) && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", (n < 300), 1);
    step();
  endtask

  // Monitor: compares each done pulse against the scoreboard head.
  logic [2:0] prev_sel [2];
  logic       prev_a   [2];
  logic       prev_rst = 1'b1;
  int         pcnt     [2];

  always @(negedge clk) begin
    logic [2:0] sel_v;
    logic       a_v, done_v;
    exp_t       e;
    for (int k = 0; k < 2; k++) begin
      sel_v  = (k == 0) ? {s0_2, s0_1, s0_0} : {s1_2, s1_1, s1_0};
      a_v    = (k == 0) ? a0 : a1;
      done_v = (k == 0) ? done0 : done1;
      if (rst) begin
        pcnt[k] = 0;
      end else begin
        if (a_v) pcnt[k]++;
        if (!prev_rst && (sel_v != prev_sel[k]))
          chk("sel_moved_with_a_high", {30'd0, a_v, prev_a[k]}, 0);
        if (done_v) begin
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            chk("done_unexpected", 1, 0);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk("done_sel", {29'd0, sel_v}, {29'd0, e.dest});
            chk("done_a_cycles", pcnt[k], e.data ? ((k == 0) ? 1 : 3) : 0);
            chk("done_cycle", cyc, e.cyc);
          end
          pcnt[k] = 0;
        end
      end
      prev_sel[k] = sel_v;
      prev_a[k]   = a_v;
    end
    prev_rst = rst;
  end

  logic [2:0] full_dest [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic       full_rdy  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int t;
    rst = 1'b1;
    last_done[0] = 0;
    last_done[1] = 0;
    drive(0, 1'b0, 3'd0, 1'b0);
    drive(1, 1'b0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", a0, 0);
    chk("rst_sel", {s0_2, s0_1, s0_0}, 0);
    chk("rst_done", done0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_level", level0, 0);
    chk("rst_ready", if0.in_ready, 1);
    chk("rst_a_pl3", a1, 0);
    rst = 1'b0;
    step();

    // Single request dest=5 data=1, cycle-exact waveform.
    t = cyc;
    send(0, 3'd5, 1'b1);
    step(); chk("single_c2_sel", {s0_2, s0_1, s0_0}, 5); chk("single_c2_a", a0, 0);
    step(); chk("single_c3_a", a0, 1);
    step(); chk("single_c4_a", a0, 0); chk("single_c4_done", done0, 1);
    step(); chk("single_c5_busy", busy0, 0); chk("single_c5_cycle", cyc, t + 5);
    drain();

    // Back-to-back 0,3,7: done at +4, +7, +10.
    send(0, 3'd0, 1'b1);
    send(0, 3'd3, 1'b1);
    send(0, 3'd7, 1'b1);
    drain();

    // data=0 request still runs the whole sequence.
    send(0, 3'd2, 1'b0);
    step(); chk("data0_sel", {s0_2, s0_1, s0_0}, 2);
    drain();

    // Fill the FIFO: pushes at cycles 6 and 7 must be refused.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b1, full_dest[i], 1'b1);
      chk("full_ready", if0.in_ready, full_rdy[i]);
      if (i == 6) chk("full_level", level0, 4);
      if (full_rdy[i]) push_exp(0, full_dest[i], 1'b1);
      step();
    end
    drive(0, 1'b0, 3'd0, 1'b0);
    drain();

    // PULSE_LEN=3: dest=6, then back-to-back with a data=0 entry.
    send(1, 3'd6, 1'b1);
    step(); chk("pl3_setup_sel", {s1_2, s1_1, s1_0}, 6);
    drain();
    send(1, 3'd6, 1'b1);
    send(1, 3'd1, 1'b0);
    send(1, 3'd4, 1'b1);
    drain();

    // Reset in the middle of a pulse discards everything queued.
    send(0, 3'd1, 1'b1);
    send(0, 3'd2, 1'b1);
    send(0, 3'd3, 1'b1);
    t = 0;
    while (a0 !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    chk("mid_rst_pulse_seen", a0, 1);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    last_done[0] = 0;
    last_done[1] = 0;
    step();
    chk("mid_rst_a_next", a0, 0);
    chk("mid_rst_done_next", done0, 0);
    step();
    rst = 1'b0;
    chk("mid_rst_sel", {s0_2, s0_1, s0_0}, 0);
    chk("mid_rst_level", level0, 0);
    chk("mid_rst_ready", if0.in_ready, 1);
    chk("mid_rst_busy", busy0, 0);
    repeat (15) step();
    chk("post_rst_idle", busy0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
